ibex_rf_wb_arbiter: RTL and testbench

- Shares the single register-file write port between two writeback sources: port A (ALU/ID-stage result) and port B (LSU load data).
- Each source gets a one-entry holding buffer with a valid/ready handshake.
- The block arbitrates between the buffers, drives the register-file write port from registered outputs, and flags read-after-write hazards for the two decode read ports.
- Sits between the execute/LSU writeback paths and the register file.

---
 rtl/ibex_rf_wb_arbiter.sv | 144 ++++++++++++++
 tb/tb_ibex_rf_wb_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ibex_rf_wb_arbiter.sv
// Shares the RF write port between ALU (A) and LSU (B) one-entry buffers; 2 edges handshake->rf_we_o when uncontested.
// Backpressure: x_ready_o drops only while buffer x is full and loses arbitration; A wins after MaxStall lost cycles.
module ibex_rf_wb_arbiter #(
    parameter int unsigned DataWidth = 32,
    parameter int unsigned MaxStall  = 3
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 a_valid_i,
    output logic                 a_ready_o,
    input  logic [4:0]           a_waddr_i,
    input  logic [DataWidth-1:0] a_wdata_i,
    input  logic                 b_valid_i,
    output logic                 b_ready_o,
    input  logic [4:0]           b_waddr_i,
    input  logic [DataWidth-1:0] b_wdata_i,
    output logic                 rf_we_o,
    output logic [4:0]           rf_waddr_o,
    output logic [DataWidth-1:0] rf_wdata_o,
    input  logic [4:0]           raddr_a_i,
    input  logic [4:0]           raddr_b_i,
    output logic                 hazard_a_o,
    output logic                 hazard_b_o
);
    localparam int unsigned CntW = $clog2(MaxStall + 1);
    localparam logic [CntW-1:0] StallMax = CntW'(MaxStall);

    logic                 hold_v_a_q, hold_v_a_d, hold_v_b_q, hold_v_b_d;
    logic [4:0]           hold_addr_a_q, hold_addr_a_d, hold_addr_b_q, hold_addr_b_d;
    logic [DataWidth-1:0] hold_data_a_q, hold_data_a_d, hold_data_b_q, hold_data_b_d;
    logic                 age_a_q, age_a_d;
    logic [CntW-1:0]      stall_cnt_q, stall_cnt_d;
    logic                 rf_we_q, rf_we_d;
    logic [4:0]           rf_waddr_q, rf_waddr_d;
    logic [DataWidth-1:0] rf_wdata_q, rf_wdata_d;

    logic grant_a, grant_b, load_a, load_b;

    // age_a_q = 1 means the A entry was buffered before the B entry.
    always_comb begin
        grant_a = 1'b0;
        if (hold_v_a_q) begin
            if (!hold_v_b_q) begin
                grant_a = 1'b1;
            end else if (hold_addr_a_q == hold_addr_b_q) begin
                grant_a = age_a_q;
            end else begin
                grant_a = (stall_cnt_q == StallMax);
            end
        end
        grant_b = hold_v_b_q & ~grant_a;
    end

    assign a_ready_o = ~hold_v_a_q | grant_a;
    assign b_ready_o = ~hold_v_b_q | grant_b;
    assign load_a    = a_valid_i & a_ready_o & (a_waddr_i != 5'd0);
    assign load_b    = b_valid_i & b_ready_o & (b_waddr_i != 5'd0);

    always_comb begin
        hold_v_a_d    = hold_v_a_q & ~grant_a;
        hold_addr_a_d = hold_addr_a_q;
        hold_data_a_d = hold_data_a_q;
        hold_v_b_d    = hold_v_b_q & ~grant_b;
        hold_addr_b_d = hold_addr_b_q;
        hold_data_b_d = hold_data_b_q;
        age_a_d       = age_a_q;
        if (load_a) begin
            hold_v_a_d    = 1'b1;
            hold_addr_a_d = a_waddr_i;
            hold_data_a_d = a_wdata_i;
        end
        if (load_b) begin
            hold_v_b_d    = 1'b1;
            hold_addr_b_d = b_waddr_i;
            hold_data_b_d = b_wdata_i;
        end
        // A newly loaded entry is younger than whatever the other buffer keeps.
        if (load_a && load_b) begin
            age_a_d = 1'b1;
        end else if (load_a) begin
            age_a_d = 1'b0;
        end else if (load_b) begin
            age_a_d = 1'b1;
        end

        stall_cnt_d = '0;
        if (hold_v_a_q && !grant_a) begin
            stall_cnt_d = (stall_cnt_q == StallMax) ? stall_cnt_q : stall_cnt_q + 1'b1;
        end

        rf_we_d    = grant_a | grant_b;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        if (grant_a) begin
            rf_waddr_d = hold_addr_a_q;
            rf_wdata_d = hold_data_a_q;
        end else if (grant_b) begin
            rf_waddr_d = hold_addr_b_q;
            rf_wdata_d = hold_data_b_q;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hold_v_a_q    <= 1'b0;
            hold_addr_a_q <= '0;
            hold_data_a_q <= '0;
            hold_v_b_q    <= 1'b0;
            hold_addr_b_q <= '0;
            hold_data_b_q <= '0;
            age_a_q       <= 1'b0;
            stall_cnt_q   <= '0;
            rf_we_q       <= 1'b0;
            rf_waddr_q    <= '0;
            rf_wdata_q    <= '0;
        end else begin
            hold_v_a_q    <= hold_v_a_d;
            hold_addr_a_q <= hold_addr_a_d;
            hold_data_a_q <= hold_data_a_d;
            hold_v_b_q    <= hold_v_b_d;
            hold_addr_b_q <= hold_addr_b_d;
            hold_data_b_q <= hold_data_b_d;
            age_a_q       <= age_a_d;
            stall_cnt_q   <= stall_cnt_d;
            rf_we_q       <= rf_we_d;
            rf_waddr_q    <= rf_waddr_d;
            rf_wdata_q    <= rf_wdata_d;
        end
    end

    assign rf_we_o    = rf_we_q;
    assign rf_waddr_o = rf_waddr_q;
    assign rf_wdata_o = rf_wdata_q;

    // The rf_we term covers the cycle before the register file holds the new value.
    assign hazard_a_o = (raddr_a_i != 5'd0) &
                        ((hold_v_a_q & (hold_addr_a_q == raddr_a_i)) |
                         (hold_v_b_q & (hold_addr_b_q == raddr_a_i)) |
                         (rf_we_q & (rf_waddr_q == raddr_a_i)));
    assign hazard_b_o = (raddr_b_i != 5'd0) &
                        ((hold_v_a_q & (hold_addr_a_q == raddr_b_i)) |
                         (hold_v_b_q & (hold_addr_b_q == raddr_b_i)) |
                         (rf_we_q & (rf_waddr_q == raddr_b_i)));
endmodule

// File: tb/tb_ibex_rf_wb_arbiter.sv
// Bench for ibex_rf_wb_arbiter: directed scenarios plus randomized traffic against a timestamp-based reference model.
module tb_ibex_rf_wb_arbiter;
    localparam int DW = 32;
    localparam int MS = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          a_valid_i, b_valid_i;
    logic [4:0]    a_waddr_i, b_waddr_i, raddr_a_i, raddr_b_i;
    logic [DW-1:0] a_wdata_i, b_wdata_i;
    logic          a_ready_o, b_ready_o, rf_we_o, hazard_a_o, hazard_b_o;
    logic [4:0]    rf_waddr_o;
    logic [DW-1:0] rf_wdata_o;

    int n_cmp = 0;
    int n_bad = 0;

    ibex_rf_wb_arbiter #(.DataWidth(DW), .MaxStall(MS)) dut (
        .clk_i(clk), .rst_i(rst),
        .a_valid_i(a_valid_i), .a_ready_o(a_ready_o), .a_waddr_i(a_waddr_i), .a_wdata_i(a_wdata_i),
        .b_valid_i(b_valid_i), .b_ready_o(b_ready_o), .b_waddr_i(b_waddr_i), .b_wdata_i(b_wdata_i),
        .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o),
        .raddr_a_i(raddr_a_i), .raddr_b_i(raddr_b_i),
        .hazard_a_o(hazard_a_o), .hazard_b_o(hazard_b_o)
    );

    always #5 clk = ~clk;

    // Reference model: each held entry carries the cycle it was buffered in; A's lost cycles are counted.
    bit            ma_v, mb_v;
    logic [4:0]    ma_addr, mb_addr;
    logic [DW-1:0] ma_data, mb_data;
    int            ma_stamp, mb_stamp, mloss, cyc;
    bit            mrf_we;
    logic [4:0]    mrf_addr;
    logic [DW-1:0] mrf_data;

    function automatic int m_win();
        if (ma_v && mb_v) begin
            if (ma_addr == mb_addr) return (ma_stamp <= mb_stamp) ? 1 : 2;
            return (mloss >= MS) ? 1 : 2;
        end
        if (ma_v) return 1;
        if (mb_v) return 2;
        return 0;
    endfunction

    function automatic bit m_ready_a();
        return !ma_v || (m_win() == 1);
    endfunction

    function automatic bit m_ready_b();
        return !mb_v || (m_win() == 2);
    endfunction

    function automatic bit m_hazard(input logic [4:0] ra);
        return (ra != 5'd0) && ((ma_v && ma_addr == ra) || (mb_v && mb_addr == ra) || (mrf_we && mrf_addr == ra));
    endfunction

    task automatic model_reset();
        ma_v = 0; mb_v = 0; mloss = 0; cyc = 0;
        ma_stamp = 0; mb_stamp = 0;
        ma_addr = '0; mb_addr = '0; ma_data = '0; mb_data = '0;
        mrf_we = 0; mrf_addr = '0; mrf_data = '0;
    endtask

    task automatic model_step();
        int w;
        bit acc_a, acc_b;
        w = m_win();
        acc_a = a_valid_i && (!ma_v || w == 1);
        acc_b = b_valid_i && (!mb_v || w == 2);
        if (ma_v && w != 1) mloss = (mloss < MS) ? mloss + 1 : MS;
        else mloss = 0;
        if (w == 1) begin
            mrf_we = 1; mrf_addr = ma_addr; mrf_data = ma_data; ma_v = 0;
        end else if (w == 2) begin
            mrf_we = 1; mrf_addr = mb_addr; mrf_data = mb_data; mb_v = 0;
        end else begin
            mrf_we = 0;
        end
        if (acc_a && a_waddr_i != 5'd0) begin
            ma_v = 1; ma_addr = a_waddr_i; ma_data = a_wdata_i; ma_stamp = cyc;
        end
        if (acc_b && b_waddr_i != 5'd0) begin
            mb_v = 1; mb_addr = b_waddr_i; mb_data = b_wdata_i; mb_stamp = cyc;
        end
        cyc++;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        a_valid_i = 0; b_valid_i = 0;
        a_waddr_i = '0; b_waddr_i = '0; a_wdata_i = '0; b_wdata_i = '0;
        raddr_a_i = '0; raddr_b_i = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        raddr_a_i = 5'd5; raddr_b_i = 5'd6;
        model_reset();
        #1;
        n_cmp++; if (rf_we_o !== 1'b0) begin n_bad++; $display("FAIL reset_we got %b want 0", rf_we_o); end
        n_cmp++; if (rf_waddr_o !== 5'd0) begin n_bad++; $display("FAIL reset_waddr got %0d want 0", rf_waddr_o); end
        n_cmp++; if (rf_wdata_o !== '0) begin n_bad++; $display("FAIL reset_wdata got %h want 0", rf_wdata_o); end
        n_cmp++; if ({a_ready_o, b_ready_o} !== 2'b11) begin n_bad++; $display("FAIL reset_ready got %b%b want 11", a_ready_o, b_ready_o); end
        n_cmp++; if ({hazard_a_o, hazard_b_o} !== 2'b00) begin n_bad++; $display("FAIL reset_hazard got %b%b want 00", hazard_a_o, hazard_b_o); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        idle_inputs();
    endtask

    task automatic test_single_stream();
        bit            exp_we[5]   = '{0, 1, 1, 1, 0};
        logic [4:0]    exp_ad[5]   = '{5'd0, 5'd5, 5'd6, 5'd7, 5'd0};
        logic [DW-1:0] exp_da[5]   = '{32'h0, 32'h11, 32'h22, 32'h33, 32'h0};
        for (int i = 0; i < 5; i++) begin
            if (i < 3) begin
                a_valid_i = 1; a_waddr_i = 5'(5 + i); a_wdata_i = 32'(17 * (i + 1));
                #1;
                n_cmp++; if (a_ready_o !== 1'b1) begin n_bad++; $display("FAIL stream_ready[%0d] got %b want 1", i, a_ready_o); end
            end else begin
                a_valid_i = 0;
            end
            tick();
            n_cmp++;
            if (rf_we_o !== exp_we[i] || (exp_we[i] && (rf_waddr_o !== exp_ad[i] || rf_wdata_o !== exp_da[i]))) begin
                n_bad++;
                $display("FAIL stream_write[%0d] got we=%b x%0d=%h want we=%b x%0d=%h",
                         i, rf_we_o, rf_waddr_o, rf_wdata_o, exp_we[i], exp_ad[i], exp_da[i]);
            end
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_starvation();
        int         exp_ad[9] = '{2, 3, 4, 1, 5, 6, 7, 8, 9};
        int         got_ad[$], got_tk[$];
        logic [DW-1:0] got_da[$];
        int         bi;
        bit         a_acc, b_acc;
        logic [DW-1:0] want_d;
        bi = 2;
        a_valid_i = 1; a_waddr_i = 5'd1; a_wdata_i = 32'hA;
        b_valid_i = 1; b_waddr_i = 5'd2; b_wdata_i = 32'h102;
        for (int t = 1; t <= 14; t++) begin
            #1;
            a_acc = a_valid_i && a_ready_o;
            b_acc = b_valid_i && b_ready_o;
            tick();
            if (a_acc) a_valid_i = 0;
            if (b_acc) begin
                bi++;
                if (bi <= 9) begin b_waddr_i = 5'(bi); b_wdata_i = 32'(256 + bi); end
                else b_valid_i = 0;
            end
            if (rf_we_o) begin
                got_ad.push_back(int'(rf_waddr_o)); got_da.push_back(rf_wdata_o); got_tk.push_back(t);
            end
        end
        n_cmp++; if (got_ad.size() != 9) begin n_bad++; $display("FAIL starve_count got %0d want 9", got_ad.size()); end
        for (int j = 0; j < 9 && j < got_ad.size(); j++) begin
            want_d = (exp_ad[j] == 1) ? 32'hA : 32'(256 + exp_ad[j]);
            n_cmp++;
            if (got_ad[j] != exp_ad[j] || got_da[j] !== want_d || got_tk[j] != j + 2) begin
                n_bad++;
                $display("FAIL starve_write[%0d] got x%0d=%h @%0d want x%0d=%h @%0d",
                         j, got_ad[j], got_da[j], got_tk[j], exp_ad[j], want_d, j + 2);
            end
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_same_addr();
        int            exp_tk[3] = '{2, 3, 4};
        int            exp_ad[3] = '{9, 4, 4};
        logic [DW-1:0] exp_da[3] = '{32'h99, 32'h1, 32'h2};
        int            k;
        a_valid_i = 1; a_waddr_i = 5'd4; a_wdata_i = 32'h1;
        b_valid_i = 1; b_waddr_i = 5'd9; b_wdata_i = 32'h99;
        tick();
        a_valid_i = 0;
        b_waddr_i = 5'd4; b_wdata_i = 32'h2;
        #1;
        n_cmp++; if (b_ready_o !== 1'b1) begin n_bad++; $display("FAIL same_b_ready got %b want 1", b_ready_o); end
        k = 0;
        for (int t = 2; t <= 6; t++) begin
            tick();
            b_valid_i = 0;
            if (rf_we_o) begin
                n_cmp++;
                if (k >= 3 || t != exp_tk[k] || int'(rf_waddr_o) != exp_ad[k] || rf_wdata_o !== exp_da[k]) begin
                    n_bad++;
                    $display("FAIL same_write[%0d] got x%0d=%h @%0d", k, rf_waddr_o, rf_wdata_o, t);
                end
                k++;
            end
        end
        n_cmp++; if (k != 3) begin n_bad++; $display("FAIL same_count got %0d want 3", k); end
        idle_inputs();
    endtask

    task automatic test_x0();
        b_valid_i = 1; b_waddr_i = 5'd0; b_wdata_i = 32'hDEAD;
        raddr_a_i = 5'd0; raddr_b_i = 5'd0;
        #1;
        n_cmp++; if (b_ready_o !== 1'b1) begin n_bad++; $display("FAIL x0_ready got %b want 1", b_ready_o); end
        tick();
        b_valid_i = 0;
        for (int t = 0; t < 3; t++) begin
            n_cmp++;
            if (rf_we_o !== 1'b0 || hazard_a_o !== 1'b0) begin
                n_bad++;
                $display("FAIL x0_nowrite[%0d] got we=%b haz_a=%b want 0 0", t, rf_we_o, hazard_a_o);
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_hazard();
        bit exp_hz[3] = '{1, 1, 0};
        bit exp_we[3] = '{0, 1, 0};
        raddr_b_i = 5'd3; raddr_a_i = 5'd0;
        a_valid_i = 1; a_waddr_i = 5'd3; a_wdata_i = 32'h333;
        #1;
        n_cmp++; if (hazard_b_o !== 1'b0) begin n_bad++; $display("FAIL hazard_pre got %b want 0", hazard_b_o); end
        for (int t = 0; t < 3; t++) begin
            tick();
            a_valid_i = 0;
            n_cmp++;
            if (hazard_b_o !== exp_hz[t] || rf_we_o !== exp_we[t]) begin
                n_bad++;
                $display("FAIL hazard_seq[%0d] got haz=%b we=%b want haz=%b we=%b", t, hazard_b_o, rf_we_o, exp_hz[t], exp_we[t]);
            end
        end
        idle_inputs();
    endtask

    task automatic test_reset_midstream();
        a_valid_i = 1; a_waddr_i = 5'd10; a_wdata_i = 32'h10;
        b_valid_i = 1; b_waddr_i = 5'd11; b_wdata_i = 32'h11;
        tick();
        a_valid_i = 0;
        b_waddr_i = 5'd12; b_wdata_i = 32'h12;
        tick();
        idle_inputs();
        raddr_a_i = 5'd10; raddr_b_i = 5'd12;
        #1;
        n_cmp++; if (rf_we_o !== 1'b1 || hazard_a_o !== 1'b1) begin n_bad++; $display("FAIL mid_pre got we=%b haz_a=%b want 1 1", rf_we_o, hazard_a_o); end
        #1;
        rst = 1'b1;
        #1;
        n_cmp++; if (rf_we_o !== 1'b0) begin n_bad++; $display("FAIL mid_we got %b want 0", rf_we_o); end
        n_cmp++; if ({a_ready_o, b_ready_o} !== 2'b11) begin n_bad++; $display("FAIL mid_ready got %b%b want 11", a_ready_o, b_ready_o); end
        n_cmp++; if ({hazard_a_o, hazard_b_o} !== 2'b00) begin n_bad++; $display("FAIL mid_hazard got %b%b want 00", hazard_a_o, hazard_b_o); end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int t = 0; t < 4; t++) begin
            tick();
            n_cmp++; if (rf_we_o !== 1'b0) begin n_bad++; $display("FAIL mid_after[%0d] got we=%b want 0", t, rf_we_o); end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 800; c++) begin
            n_cmp++;
            if (rf_we_o !== mrf_we || (mrf_we && (rf_waddr_o !== mrf_addr || rf_wdata_o !== mrf_data))) begin
                n_bad++;
                $display("FAIL rand_rf[%0d] got we=%b x%0d=%h want we=%b x%0d=%h", c, rf_we_o, rf_waddr_o, rf_wdata_o, mrf_we, mrf_addr, mrf_data);
            end
            n_cmp++;
            if (a_ready_o !== m_ready_a() || b_ready_o !== m_ready_b()) begin
                n_bad++;
                $display("FAIL rand_ready[%0d] got %b%b want %b%b", c, a_ready_o, b_ready_o, m_ready_a(), m_ready_b());
            end
            n_cmp++;
            if (hazard_a_o !== m_hazard(raddr_a_i) || hazard_b_o !== m_hazard(raddr_b_i)) begin
                n_bad++;
                $display("FAIL rand_hazard[%0d] got %b%b want %b%b", c, hazard_a_o, hazard_b_o, m_hazard(raddr_a_i), m_hazard(raddr_b_i));
            end
            if (!(a_valid_i && !m_ready_a())) begin
                a_valid_i = ($urandom_range(0, 99) < 60);
                a_waddr_i = 5'($urandom_range(0, 7));
                a_wdata_i = $urandom;
            end
            if (!(b_valid_i && !m_ready_b())) begin
                b_valid_i = ($urandom_range(0, 99) < 60);
                b_waddr_i = 5'($urandom_range(0, 7));
                b_wdata_i = $urandom;
            end
            raddr_a_i = 5'($urandom_range(0, 7));
            raddr_b_i = 5'($urandom_range(0, 7));
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_single_stream();
        test_starvation();
        test_same_addr();
        test_x0();
        test_hazard();
        test_reset_midstream();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
